icache_control: RTL
===================

Name: icache_control

Overview:
- FSM controller that sequences the 2-way instruction-cache datapath: hit detection, miss fetch from physical memory, line fill and re-lookup.
- Sits between the IF stage (mem_read/mem_resp) and the arbiter/pmem side (pmem_read/pmem_resp).
- Drives the datapath control strobes load_data, valid_in and load_waddr, and consumes hit_any.
- The icache is read-only, so there is no writeback path.

Parameters:
- FETCH_TIMEOUT, default 0: cycles allowed in FETCH before fetch_err pulses; 0 disables the watchdog.
- CNT_W, default 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  IF read request; held high until mem_resp.
- mem_resp  out  1  read data valid this cycle; datapath mem_rdata256 is valid.
- hit_any  in  1  combinational tag-match result from the datapath.
- load_data  out  1  write pmem line into the LRU way at the current index.
- valid_in  out  1  valid bit written with load_data.
- load_waddr  out  1  selects the victim-tag address; tied 0 (no writeback).
- pmem_read  out  1  line fetch request to the arbiter.
- pmem_resp  in  1  fetch data valid on pmem_rdata; single-cycle pulse.
- fetch_err  out  1  one-cycle pulse when the FETCH watchdog expires.
- hit_count  out  CNT_W  hits counted; present only with the macro.
- miss_count  out  CNT_W  misses counted; present only with the macro.

Behaviour:
- States: CHECK (reset state), FETCH, FILL.
- Reset (rst=0, asynchronous):
  - state=CHECK; watchdog counter=0.
  - All outputs 0, counters 0.
  - A reset during FETCH drops pmem_read immediately (asynchronous clear, not on the next edge).
- CHECK:
  - mem_read=1 & hit_any=1: mem_resp=1 in the same cycle (0-cycle hit latency); stay in CHECK.
  - mem_read=1 & hit_any=0: mem_resp=0; next state FETCH.
  - mem_read=0: idle, all strobes 0.
- FETCH:
  - pmem_read=1 (Moore) every cycle in the state.
  - On pmem_resp=1: next state FILL; pmem_read is still 1 in that cycle.
  - Watchdog counts cycles in FETCH. When the count reaches FETCH_TIMEOUT (nonzero), fetch_err pulses for 1 cycle. The FSM keeps waiting; there is no abort.
- FILL:
  - load_data=1 and valid_in=1 for exactly 1 cycle; the line is written into way lru_out.
  - Next state CHECK, where the re-lookup hits and mem_resp is asserted.
- Miss latency: N+2 cycles from the miss-detect cycle to mem_resp, where N is the number of cycles pmem_resp takes after pmem_read rises.
- If mem_read drops during FETCH/FILL: the fill still completes and the FSM returns to CHECK. No mem_resp is issued.
- pmem_resp seen outside FETCH is ignored.
- mem_address must stay stable from the miss until mem_resp. This is the requester's obligation and is checked only by an assertion.
- mem_resp is never asserted outside CHECK.
- mem_resp and load_data are never high in the same cycle.
- Transitions are strictly CHECK->FETCH->FILL->CHECK; no other transitions are legal.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - hit_count increments on each CHECK cycle with mem_read & hit_any.
  - miss_count increments on each CHECK->FETCH transition.
  - Both counters saturate at all-ones (no wrap) and reset to 0.
- Undefined: the counter ports and logic are absent. FSM behaviour is identical either way.

Decomposition:
- Package icache_pkg holds:
  - the state enum icache_state_t {CHECK, FETCH, FILL}, 2 bits;
  - localparam ICACHE_WAYS=2;
  - the default FETCH_TIMEOUT.
- Sub-module icache_perf_ctr: a saturating CNT_W counter with inc input, instantiated twice under ICACHE_PERF_EN.
- The FSM and watchdog stay in icache_control.

Test Plan:
- Hit: after reset, prime one line; then mem_read=1, hit_any=1 -> mem_resp=1 in the same cycle, pmem_read stays 0, hit_count=1.
- Miss: mem_read=1, hit_any=0, pmem_resp after 5 cycles ->
  - pmem_read high for 5 cycles;
  - then load_data=valid_in=1 for 1 cycle;
  - then mem_resp on the next cycle (total 7);
  - miss_count=1.
- Abandon: drop mem_read 2 cycles into FETCH -> FILL still occurs; no mem_resp; returns to CHECK idle.
- Reset mid-fetch: assert rst=0 asynchronously during FETCH -> pmem_read=0 before the next clock edge; state CHECK after release; a stray pmem_resp is ignored.
- Watchdog: FETCH_TIMEOUT=8, pmem_resp withheld 20 cycles -> one fetch_err pulse at cycle 8; the fill completes normally when pmem_resp arrives.
- Saturation (ICACHE_PERF_EN, CNT_W=4): 20 consecutive hits -> hit_count holds at 15.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and defaults for the 2-way instruction-cache controller.
package icache_pkg;

   typedef enum logic [1:0] {
      CHECK = 2'd0,
      FETCH = 2'd1,
      FILL  = 2'd2
   } icache_state_t;

   localparam int unsigned ICACHE_WAYS       = 2;
   localparam int unsigned FETCH_TIMEOUT_DEF = 0;
   localparam int unsigned CNT_W_DEF         = 32;

endpackage

// File: rtl/icache_perf_ctr.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module icache_perf_ctr
   import icache_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/icache_control.sv
// Instruction-cache controller: hit check, line fetch, fill and re-lookup.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache_control
   import icache_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   output logic             mem_resp,
   input  logic             hit_any,
   output logic             load_data,
   output logic             valid_in,
   output logic             load_waddr,
   output logic             pmem_read,
   input  logic             pmem_resp,
   output logic             fetch_err
`ifdef ICACHE_PERF_EN
   ,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
`endif
);

   localparam int unsigned WD_W     = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
   localparam bit          WD_EN    = (FETCH_TIMEOUT != 0);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(FETCH_TIMEOUT);

   icache_state_t   state_q, state_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            pmem_read_q, pmem_read_d;
   logic            load_data_q, load_data_d;
   logic            fetch_err_q, fetch_err_d;

   // Hits answer in the lookup cycle itself, so the response is decoded directly.
   assign mem_resp   = (state_q == CHECK) && mem_read && hit_any;
   assign pmem_read  = pmem_read_q;
   assign load_data  = load_data_q;
   assign valid_in   = load_data_q;
   assign load_waddr = 1'b0;
   assign fetch_err  = fetch_err_q;

   always_comb begin
      state_d     = state_q;
      wd_cnt_d    = wd_cnt_q;
      pmem_read_d = 1'b0;
      load_data_d = 1'b0;
      fetch_err_d = 1'b0;

      unique case (state_q)
         CHECK: begin
            if (mem_read && !hit_any) begin
               state_d  = FETCH;
               wd_cnt_d = WD_W'(1);
            end
         end
         FETCH: begin
            if (pmem_resp) begin
               state_d = FILL;
            end else if (wd_cnt_q != WD_LIMIT) begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
         end
         FILL:    state_d = CHECK;
         default: state_d = CHECK;
      endcase

      // Watchdog counter parks at the limit, so the error fires once per fetch.
      fetch_err_d = WD_EN && (state_d == FETCH) && (wd_cnt_d == WD_LIMIT) &&
                    !((state_q == FETCH) && (wd_cnt_q == WD_LIMIT));
      pmem_read_d = (state_d == FETCH);
      load_data_d = (state_d == FILL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= CHECK;
         wd_cnt_q    <= '0;
         pmem_read_q <= 1'b0;
         load_data_q <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wd_cnt_q    <= wd_cnt_d;
         pmem_read_q <= pmem_read_d;
         load_data_q <= load_data_d;
         fetch_err_q <= fetch_err_d;
      end
   end

`ifdef ICACHE_PERF_EN
   logic miss_start;
   assign miss_start = (state_q == CHECK) && mem_read && !hit_any;

   icache_perf_ctr #(.CNT_W(CNT_W)) u_hit_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (mem_resp),
      .count (hit_count)
   );

   icache_perf_ctr #(.CNT_W(CNT_W)) u_miss_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_start),
      .count (miss_count)
   );
`endif

   ap_cnt_w_nonzero: assert property (@(posedge clk) disable iff (!rst) CNT_W != 0);

   ap_resp_excl: assert property (@(posedge clk) disable iff (!rst) !(mem_resp && load_data));

   ap_from_check: assert property (@(posedge clk) disable iff (!rst)
      (state_q == CHECK) |=> ((state_q == CHECK) || (state_q == FETCH)));

   ap_from_fetch: assert property (@(posedge clk) disable iff (!rst)
      (state_q == FETCH) |=> ((state_q == FETCH) || (state_q == FILL)));

   ap_from_fill: assert property (@(posedge clk) disable iff (!rst)
      (state_q == FILL) |=> (state_q == CHECK));

endmodule
